tx_timing_gen: RTL and testbench
================================

// Module: tx_timing_gen
//
// PURPOSE
// Parametrised TX timing generator; successor to the fixed 50MHz->1MHz trigger-aligned divider.
// Synchronises and glitch-filters the envelope-detector trigger, and produces a trigger-aligned
// divided clock. Asserts the TX switch after a runtime-programmable delay, for a
// programmable number of periods. Feeds the TX modulator/switch chain; reports completion and abort.
//
// PARAMETERS
// DIV_HALF     25  input clocks per clock_out half-period (period = 2*DIV_HALF); >=2
// SYNC_STAGES  2   trigger synchroniser flops; >=2
// MIN_PULSE    4   consecutive synchronised-high samples needed to accept trigger; >=1
// DW           12  width of cfg_delay
// LW           16  width of cfg_len
// HOLDOFF_CYC  64  input clocks after trigger low before re-arming; >=1
//
// PORTS
// clock      in   1   system clock (50MHz)
// reset      in   1   asynchronous, active-low
// trigger    in   1   envelope detector output, asynchronous to clock
// cfg_delay  in   DW  clock_out periods from first clock_out rise to switch rise
// cfg_len    in   LW  clock_out periods switch stays high; 0 = until trigger falls
// clock_out  out  1   divided clock, first rising edge aligned to accepted trigger
// switch     out  1   TX control signal, changes only with clock_out rising edge
// sym_tick   out  1   1-clock pulse in every cycle where clock_out rises
// busy       out  1   high in DELAY, ACTIVE, HOLDOFF
// done       out  1   1-clock pulse: burst completed normally (cfg_len periods elapsed)
// aborted    out  1   1-clock pulse: trigger lost in DELAY, or in ACTIVE with cfg_len!=0
//
// BEHAVIOUR
// - Reset (async, any state): all outputs 0, state IDLE, all counters 0, sync/filter flops 0.
// - Sync: trigger -> SYNC_STAGES flops -> trig_s. Filter: trig_f (registered) sets on the edge
//   where trig_s has been 1 for MIN_PULSE consecutive samples. Clears on first trig_s=0 sample.
// - Latency: trigger rise to clock_out rise = SYNC_STAGES+MIN_PULSE+1 clocks (+ sync uncertainty).
// - FSM IDLE -> DELAY: on the edge where trig_f=1. Same edge: clock_out<=1, sym_tick<=1, divcnt<=0,
//   percnt<=0. Latch cfg_delay/cfg_len; later cfg changes are ignored until next IDLE.
// - Divider (DELAY, ACTIVE): divcnt counts 0..DIV_HALF-1 and wraps. clock_out toggles on wrap.
//   Each toggle to 1 pulses sym_tick and increments percnt; percnt saturates at all-ones.
// - DELAY -> ACTIVE: on the clock_out rising edge where percnt reaches latched delay. Switch<=1 on
//   that same edge. delay=0 means switch rises with the first clock_out rise (same edge as entry).
// - ACTIVE: percnt restarts at 0 on entry. len!=0: on the len-th subsequent clock_out rising edge,
//   switch<=0, clock_out<=0, done pulse, -> HOLDOFF. len=0: stays until trig_f=0.
// - Trigger loss (trig_f=0) in DELAY or ACTIVE: next edge clock_out<=0, switch<=0, -> HOLDOFF.
//   aborted pulses, except ACTIVE with len=0, which pulses done instead (normal end).
// - Same-edge collision in ACTIVE (len reached and trig_f falls together): treat as done, not
//   aborted.
// - HOLDOFF: outputs 0. Wait for trig_f=0, then count HOLDOFF_CYC clocks. A trig_f=1 during the
//   count restarts the wait. -> IDLE. Retrigger is never accepted outside IDLE.
// - done and aborted are mutually exclusive; never both high. switch=1 implies state ACTIVE.
//
// TESTING (DIV_HALF=25, SYNC_STAGES=2, MIN_PULSE=4, HOLDOFF_CYC=64; trigger rises at cycle 0)
// 1 delay=3, len=2, trigger held: clock_out rises c7, period 50; switch 1 at c157..c256, done@c257.
// 2 delay=0, len=0: switch rises c7 with clock_out; trigger low c400 -> outputs 0 by c404, done.
// 3 glitch: trigger high 3 cycles only -> no clock_out, busy stays 0; 4-cycle pulse -> accepted.
// 4 delay=10, trigger drops c200 (DELAY) -> aborted pulse, clock_out/switch 0, never switch=1.
// 5 change cfg_delay mid-DELAY -> timing follows latched value; retrigger in HOLDOFF -> ignored
//   until 64 clean-low clocks elapse.
// 6 reset low mid-ACTIVE -> all outputs 0 immediately (async); release with trigger high -> restart.

Source files
------------

// File: rtl/tx_timing_gen_if.sv
// tx_timing_gen_if
//   Bundles the trigger/config inputs and the timing outputs of the TX timing
//   generator so that the generator and its environment share one connection.
//
//   trigger    envelope detector output, asynchronous to the system clock
//   cfg_delay  clock_out periods from first clock_out rise to switch rise
//   cfg_len    clock_out periods switch stays high (0 = until trigger falls)
//   clock_out  trigger-aligned divided clock
//   switch     TX switch control
//   sym_tick   one-clock pulse whenever clock_out rises
//   busy       generator is not idle
//   done       one-clock pulse on normal burst completion
//   aborted    one-clock pulse when the trigger is lost mid-burst
//
//   slave  : the timing generator side
//   master : the environment side (drives trigger and configuration)
interface tx_timing_gen_if #(
  parameter int DW = 12,
  parameter int LW = 16
) ();

  logic          trigger;
  logic [DW-1:0] cfg_delay;
  logic [LW-1:0] cfg_len;
  logic          clock_out;
  logic          switch;
  logic          sym_tick;
  logic          busy;
  logic          done;
  logic          aborted;

  modport slave (
    input  trigger, cfg_delay, cfg_len,
    output clock_out, switch, sym_tick, busy, done, aborted
  );

  modport master (
    output trigger, cfg_delay, cfg_len,
    input  clock_out, switch, sym_tick, busy, done, aborted
  );

endinterface

// File: rtl/tx_timing_gen.sv
// tx_timing_gen
//   Trigger-aligned TX timing generator. The asynchronous envelope trigger is
//   synchronised and glitch-filtered; an accepted trigger starts a divided
//   clock whose first rising edge coincides with acceptance. After a latched
//   number of clock_out periods the TX switch is raised, held for a latched
//   number of periods (or until the trigger drops when the length is 0), and
//   the generator then waits in a hold-off state before it re-arms.
//
//   clock  in   system clock
//   reset  in   asynchronous, active-low reset
//   bus    slave modport of tx_timing_gen_if (trigger, cfg_delay, cfg_len in;
//          clock_out, switch, sym_tick, busy, done, aborted out)
module tx_timing_gen #(
  parameter int DIV_HALF    = 25,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_PULSE   = 4,
  parameter int DW          = 12,
  parameter int LW          = 16,
  parameter int HOLDOFF_CYC = 64
) (
  input logic            clock,
  input logic            reset,
  tx_timing_gen_if.slave bus
);

  localparam int PW = (DW > LW) ? DW : LW;
  localparam int CW = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int FW = $clog2(MIN_PULSE + 1);
  localparam int HW = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, ACTIVE, HOLDOFF} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   trigS;
  logic [FW-1:0]          fCnt_q, fCnt_d;
  logic                   trigF_q, trigF_d;

  state_t        state_q, state_d;
  logic [CW-1:0] divCnt_q, divCnt_d;
  logic [PW-1:0] perCnt_q, perCnt_d;
  logic [HW-1:0] holdCnt_q, holdCnt_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [LW-1:0] len_q, len_d;
  logic          clockOut_q, clockOut_d;
  logic          switch_q, switch_d;
  logic          symTick_q, symTick_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;

  logic          divWrap;
  logic          clkRise;
  logic [PW-1:0] perNext;
  logic          endBurst;

  // Trigger synchroniser: plain shift chain, oldest sample is trigS.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.trigger};
  end

  assign trigS = sync_q[SYNC_STAGES-1];

  // Glitch filter: fCnt counts consecutive high samples; the MIN_PULSE-th
  // one sets trigF. Any low sample clears both immediately.
  always_comb begin
    fCnt_d  = '0;
    trigF_d = 1'b0;
    if (trigS) begin
      if (trigF_q || fCnt_q == FW'(MIN_PULSE - 1)) begin
        trigF_d = 1'b1;
        fCnt_d  = fCnt_q;
      end else begin
        fCnt_d = fCnt_q + 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fCnt_q     <= '0;
      trigF_q    <= 1'b0;
      state_q    <= IDLE;
      divCnt_q   <= '0;
      perCnt_q   <= '0;
      holdCnt_q  <= '0;
      delay_q    <= '0;
      len_q      <= '0;
      clockOut_q <= 1'b0;
      switch_q   <= 1'b0;
      symTick_q  <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      fCnt_q     <= fCnt_d;
      trigF_q    <= trigF_d;
      state_q    <= state_d;
      divCnt_q   <= divCnt_d;
      perCnt_q   <= perCnt_d;
      holdCnt_q  <= holdCnt_d;
      delay_q    <= delay_d;
      len_q      <= len_d;
      clockOut_q <= clockOut_d;
      switch_q   <= switch_d;
      symTick_q  <= symTick_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  // Next-state logic. A burst end (normal or abort) is collected in endBurst
  // so that it overrides any divider activity on the same edge.
  always_comb begin
    state_d    = state_q;
    divCnt_d   = divCnt_q;
    perCnt_d   = perCnt_q;
    holdCnt_d  = holdCnt_q;
    delay_d    = delay_q;
    len_d      = len_q;
    clockOut_d = clockOut_q;
    switch_d   = switch_q;
    symTick_d  = 1'b0;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    endBurst   = 1'b0;

    divWrap = (divCnt_q == CW'(DIV_HALF - 1));
    clkRise = divWrap && !clockOut_q;
    perNext = (&perCnt_q) ? perCnt_q : perCnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        clockOut_d = 1'b0;
        switch_d   = 1'b0;
        divCnt_d   = '0;
        perCnt_d   = '0;
        holdCnt_d  = '0;
        if (trigF_q) begin
          state_d    = DELAY;
          clockOut_d = 1'b1;
          symTick_d  = 1'b1;
          delay_d    = bus.cfg_delay;
          len_d      = bus.cfg_len;
          // Zero delay: the switch goes up with the very first clock_out rise.
          if (bus.cfg_delay == '0) begin
            state_d  = ACTIVE;
            switch_d = 1'b1;
          end
        end
      end

      DELAY, ACTIVE: begin
        divCnt_d = divWrap ? '0 : divCnt_q + 1'b1;
        if (divWrap) clockOut_d = !clockOut_q;
        if (clkRise) begin
          symTick_d = 1'b1;
          perCnt_d  = perNext;
        end
        if (state_q == DELAY) begin
          // Trigger loss wins over reaching the delay on the same edge.
          if (!trigF_q) begin
            endBurst  = 1'b1;
            aborted_d = 1'b1;
          end else if (clkRise && perNext == PW'(delay_q)) begin
            state_d  = ACTIVE;
            switch_d = 1'b1;
            perCnt_d = '0;
          end
        end else begin
          // Reaching the length wins over trigger loss on the same edge.
          if (clkRise && len_q != '0 && perNext == PW'(len_q)) begin
            endBurst = 1'b1;
            done_d   = 1'b1;
          end else if (!trigF_q) begin
            endBurst = 1'b1;
            if (len_q == '0) done_d    = 1'b1;
            else             aborted_d = 1'b1;
          end
        end
      end

      HOLDOFF: begin
        clockOut_d = 1'b0;
        switch_d   = 1'b0;
        if (trigF_q) begin
          holdCnt_d = '0;
        end else if (holdCnt_q == HW'(HOLDOFF_CYC - 1)) begin
          state_d   = IDLE;
          holdCnt_d = '0;
        end else begin
          holdCnt_d = holdCnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (endBurst) begin
      state_d    = HOLDOFF;
      clockOut_d = 1'b0;
      switch_d   = 1'b0;
      symTick_d  = 1'b0;
      divCnt_d   = '0;
      perCnt_d   = '0;
      holdCnt_d  = '0;
    end
  end

  assign bus.clock_out = clockOut_q;
  assign bus.switch    = switch_q;
  assign bus.sym_tick  = symTick_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_tx_timing_gen.sv
// tb_tx_timing_gen
//   Directed scenarios for tx_timing_gen with an event scoreboard. Each
//   scenario pushes the hand-computed cycle of every sym_tick, switch edge,
//   done and aborted pulse; a negedge monitor pops and compares as the DUT
//   produces them. Cycle numbers are relative to the clock edge after which
//   the trigger was raised.
module tb_tx_timing_gen;

  typedef enum int {EV_TICK, EV_SWON, EV_SWOFF, EV_DONE, EV_ABORT} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   base = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic swPrev = 1'b0;
  ev_t  expQ[$];

  tx_timing_gen_if #(.DW(12), .LW(16)) bus ();

  tx_timing_gen #(
    .DIV_HALF(25), .SYNC_STAGES(2), .MIN_PULSE(4),
    .DW(12), .LW(16), .HOLDOFF_CYC(64)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic expectEvent(ev_kind_t k, int rel);
    ev_t e;
    e.kind = k;
    e.cyc  = base + rel;
    expQ.push_back(e);
  endtask

  task automatic scoreEvent(ev_kind_t k);
    ev_t e;
    vectors++;
    if (expQ.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL event: got %s at c%0d, expected no event", k.name(), cyc - base);
    end else begin
      e = expQ.pop_front();
      if (e.kind != k || e.cyc != cyc) begin
        miscompares++;
        $display("[TB] FAIL event: got %s at c%0d, expected %s at c%0d",
                 k.name(), cyc - base, e.kind.name(), e.cyc - base);
      end
    end
  endtask

  // Monitor: fixed per-cycle order TICK, SWON, SWOFF, DONE, ABORT.
  always @(negedge clock) begin
    if (bus.sym_tick) scoreEvent(EV_TICK);
    if (bus.switch && !swPrev) scoreEvent(EV_SWON);
    if (!bus.switch && swPrev) scoreEvent(EV_SWOFF);
    if (bus.done) scoreEvent(EV_DONE);
    if (bus.aborted) scoreEvent(EV_ABORT);
    swPrev = bus.switch;
  end

  task automatic checkOutput(string name, logic act, logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b, expected %b (c%0d)", name, act, exp, cyc - base);
    end
  endtask

  task automatic drainCheck(string name);
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL %s: %0d expected events missing, first %s at c%0d",
               name, expQ.size(), expQ[0].kind.name(), expQ[0].cyc - base);
      expQ.delete();
    end
  endtask

  // Runs until base+rel edges have passed; returns 1 time unit after that edge.
  task automatic waitTo(int rel);
    while (cyc < base + rel) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(int d, int l);
    bus.cfg_delay = 12'(d);
    bus.cfg_len   = 16'(l);
    bus.trigger   = 1'b1;
    base          = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.trigger   = 1'b0;
    bus.cfg_delay = '0;
    bus.cfg_len   = '0;
    reset         = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rst clock_out", bus.clock_out, 1'b0);
    checkOutput("rst switch", bus.switch, 1'b0);
    checkOutput("rst sym_tick", bus.sym_tick, 1'b0);
    checkOutput("rst busy", bus.busy, 1'b0);
    checkOutput("rst done", bus.done, 1'b0);
    checkOutput("rst aborted", bus.aborted, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // 1: delay=3, len=2, trigger held through the burst.
    applyStimulus(3, 2);
    for (int k = 0; k < 5; k++) begin
      expectEvent(EV_TICK, 7 + 50 * k);
      if (k == 3) expectEvent(EV_SWON, 157);
    end
    expectEvent(EV_SWOFF, 257);
    expectEvent(EV_DONE, 257);
    waitTo(6);
    checkOutput("t1 latency c6", bus.clock_out, 1'b0);
    waitTo(7);
    checkOutput("t1 latency c7", bus.clock_out, 1'b1);
    checkOutput("t1 busy c7", bus.busy, 1'b1);
    waitTo(300);
    checkOutput("t1 holdoff held", bus.busy, 1'b1);
    bus.trigger = 1'b0;
    waitTo(366);
    checkOutput("t1 busy c366", bus.busy, 1'b1);
    waitTo(367);
    checkOutput("t1 busy c367", bus.busy, 1'b0);
    drainCheck("t1 events");

    // 2: delay=0, len=0, switch until trigger falls at c400.
    applyStimulus(0, 0);
    for (int k = 0; k < 8; k++) begin
      expectEvent(EV_TICK, 7 + 50 * k);
      if (k == 0) expectEvent(EV_SWON, 7);
    end
    expectEvent(EV_SWOFF, 404);
    expectEvent(EV_DONE, 404);
    waitTo(400);
    bus.trigger = 1'b0;
    waitTo(403);
    checkOutput("t2 switch c403", bus.switch, 1'b1);
    waitTo(404);
    checkOutput("t2 switch c404", bus.switch, 1'b0);
    checkOutput("t2 clock_out c404", bus.clock_out, 1'b0);
    waitTo(467);
    checkOutput("t2 busy c467", bus.busy, 1'b1);
    waitTo(468);
    checkOutput("t2 busy c468", bus.busy, 1'b0);
    drainCheck("t2 events");

    // 3: 3-cycle glitch rejected, then 4-cycle pulse accepted and lost.
    bus.trigger = 1'b1;
    base = cyc;
    waitTo(3);
    bus.trigger = 1'b0;
    waitTo(20);
    checkOutput("t3 glitch busy", bus.busy, 1'b0);
    checkOutput("t3 glitch clock_out", bus.clock_out, 1'b0);
    applyStimulus(5, 1);
    expectEvent(EV_TICK, 7);
    expectEvent(EV_ABORT, 8);
    waitTo(4);
    bus.trigger = 1'b0;
    waitTo(7);
    checkOutput("t3 pulse busy", bus.busy, 1'b1);
    waitTo(100);
    checkOutput("t3 rearmed", bus.busy, 1'b0);
    drainCheck("t3 events");

    // 4: delay=10, trigger drops in DELAY.
    applyStimulus(10, 3);
    for (int k = 0; k < 4; k++) expectEvent(EV_TICK, 7 + 50 * k);
    expectEvent(EV_ABORT, 204);
    waitTo(200);
    bus.trigger = 1'b0;
    waitTo(204);
    checkOutput("t4 switch c204", bus.switch, 1'b0);
    checkOutput("t4 busy c204", bus.busy, 1'b1);
    waitTo(280);
    checkOutput("t4 rearmed", bus.busy, 1'b0);
    drainCheck("t4 events");

    // 5: cfg change mid-DELAY ignored; retrigger in HOLDOFF restarts the wait.
    applyStimulus(2, 1);
    expectEvent(EV_TICK, 7);
    expectEvent(EV_TICK, 57);
    expectEvent(EV_TICK, 107);
    expectEvent(EV_SWON, 107);
    expectEvent(EV_SWOFF, 157);
    expectEvent(EV_DONE, 157);
    waitTo(20);
    bus.cfg_delay = 12'd6;
    bus.cfg_len   = 16'd9;
    waitTo(200);
    bus.trigger = 1'b0;
    waitTo(230);
    bus.trigger = 1'b1;
    waitTo(240);
    bus.trigger = 1'b0;
    waitTo(267);
    checkOutput("t5 busy c267", bus.busy, 1'b1);
    waitTo(306);
    checkOutput("t5 busy c306", bus.busy, 1'b1);
    waitTo(307);
    checkOutput("t5 busy c307", bus.busy, 1'b0);
    drainCheck("t5 events");

    // 6: async reset mid-ACTIVE, released with trigger still high.
    applyStimulus(1, 0);
    expectEvent(EV_TICK, 7);
    expectEvent(EV_TICK, 57);
    expectEvent(EV_SWON, 57);
    expectEvent(EV_SWOFF, 80);
    expectEvent(EV_TICK, 97);
    expectEvent(EV_TICK, 147);
    expectEvent(EV_SWON, 147);
    expectEvent(EV_TICK, 197);
    expectEvent(EV_SWOFF, 204);
    expectEvent(EV_DONE, 204);
    waitTo(80);
    checkOutput("t6 clock_out pre", bus.clock_out, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6 clock_out async", bus.clock_out, 1'b0);
    checkOutput("t6 switch async", bus.switch, 1'b0);
    checkOutput("t6 busy async", bus.busy, 1'b0);
    waitTo(90);
    #2;
    reset = 1'b1;
    waitTo(200);
    bus.trigger = 1'b0;
    waitTo(268);
    checkOutput("t6 rearmed", bus.busy, 1'b0);
    drainCheck("t6 events");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
